// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM state encoding,
// owner identifiers and the wait-state ceiling.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'b00,
      ARB_ACCESS = 2'b01,
      ARB_RESP   = 2'b10
   } arb_state_t;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DMA = 1'b1;

   localparam int MAX_WAIT_CYCLES = 15;

endpackage

// File: rtl/mem_arb_wait_cnt.sv
// Loadable down-counter that times the memory wait states; it parks at zero
// and never wraps.
module mem_arb_wait_cnt #(
   parameter int CW = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic          zero
);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported instruction/data memory between the CPU and DMA
// ports. Define MEM_ARB_CPU_PRIORITY_EN for fixed CPU priority instead of round-robin.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW          = 16,
   parameter int DW          = 16,
   parameter int WAIT_CYCLES = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_done,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic [DW-1:0] dma_rdata,
   output logic          dma_done,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic          owner
);

   // Out-of-range wait counts are clamped to the largest supported value.
   localparam int WAIT_EFF = (WAIT_CYCLES > MAX_WAIT_CYCLES) ? MAX_WAIT_CYCLES : WAIT_CYCLES;
   localparam int CW       = (WAIT_EFF < 2) ? 1 : $clog2(WAIT_EFF + 1);
   localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT_EFF);

   arb_state_t state, state_nxt;
   logic       any_req;
   logic       grant_dma;
   logic       load;
   logic       cnt_zero;
   logic       lat_we;

`ifndef MEM_ARB_CPU_PRIORITY_EN
   logic last_owner;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_owner <= OWN_DMA;
      end else if (state == ARB_RESP) begin
         last_owner <= owner;
      end
   end
`endif

   always_comb begin
      any_req = cpu_req | dma_req;
`ifdef MEM_ARB_CPU_PRIORITY_EN
      grant_dma = dma_req & ~cpu_req;
`else
      // On a tie the port that did not win last time gets the memory.
      grant_dma = (cpu_req & dma_req) ? (last_owner == OWN_CPU) : dma_req;
`endif
   end

   mem_arb_wait_cnt #(
      .CW (CW)
   ) u_wait_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .load_val (LOAD_VAL),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ARB_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      busy      = (state != ARB_IDLE);
      cpu_done  = 1'b0;
      dma_done  = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (any_req) begin
               load      = 1'b1;
               state_nxt = ARB_ACCESS;
            end
         end
         ARB_ACCESS: begin
            mem_en = 1'b1;
            mem_we = lat_we;
            if (cnt_zero) begin
               state_nxt = ARB_RESP;
            end
         end
         ARB_RESP: begin
            cpu_done  = (owner == OWN_CPU);
            dma_done  = (owner == OWN_DMA);
            state_nxt = ARB_IDLE;
         end
         default: begin
            state_nxt = ARB_IDLE;
         end
      endcase
   end

   // Winner's command is captured once at grant and held through the access.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner     <= OWN_CPU;
         lat_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_rdata <= '0;
         dma_rdata <= '0;
      end else begin
         if (load) begin
            owner     <= grant_dma;
            lat_we    <= grant_dma ? dma_we    : cpu_we;
            mem_addr  <= grant_dma ? dma_addr  : cpu_addr;
            mem_wdata <= grant_dma ? dma_wdata : cpu_wdata;
         end
         if ((state == ARB_ACCESS) && cnt_zero && !lat_we) begin
            if (owner == OWN_DMA) begin
               dma_rdata <= mem_rdata;
            end else begin
               cpu_rdata <= mem_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: one instance with one wait
// state and a second with zero wait states.
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        reset0;
   logic        cpu_req, cpu_req0, dma_req0;
   logic        cpu_we;
   logic [15:0] cpu_addr, cpu_wdata;
   logic        dma_req, dma_we;
   logic [15:0] dma_addr, dma_wdata;
   logic [15:0] mem_rdata;

   logic [15:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
   logic        cpu_done, dma_done, mem_en, mem_we, busy, owner;

   logic [15:0] cpu_rdata0, dma_rdata0, mem_addr0, mem_wdata0;
   logic        cpu_done0, dma_done0, mem_en0, mem_we0, busy0, owner0;

   int n_assert = 0;
   int n_fail   = 0;

   logic        exp_own [4];
   logic [15:0] exp_cpu_rd, exp_dma_rd, rd_val;

   mem_port_arbiter #(.AW(16), .DW(16), .WAIT_CYCLES(1)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_rdata(dma_rdata), .dma_done(dma_done),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
   );

   mem_port_arbiter #(.AW(16), .DW(16), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset0),
      .cpu_req(cpu_req0), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata0), .cpu_done(cpu_done0),
      .dma_req(dma_req0), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_rdata(dma_rdata0), .dma_done(dma_done0),
      .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
      .mem_rdata(mem_rdata), .busy(busy0), .owner(owner0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
`ifdef MEM_ARB_CPU_PRIORITY_EN
      exp_own = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
      exp_own = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
      reset = 1'b0; reset0 = 1'b0;
      cpu_req = 1'b0; cpu_req0 = 1'b0; dma_req0 = 1'b0; cpu_we = 1'b0;
      cpu_addr = '0; cpu_wdata = '0;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
      mem_rdata = '0;

      // Reset state
      tick(); tick();
      chk("rst_busy", busy, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_done", {cpu_done, dma_done}, 0);
      chk("rst_rdata", {cpu_rdata, dma_rdata}, 0);
      chk("rst_mem_bus", {mem_we, mem_addr, mem_wdata}, 0);
      chk("rst_owner", owner, 0);
      reset = 1'b1;

      // CPU read, one wait state
      tick();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
      tick();
      chk("rd_acc1_en", mem_en, 1);
      chk("rd_acc1_addr", mem_addr, 16'h0010);
      chk("rd_acc1_we", mem_we, 0);
      chk("rd_acc1_busy_own", {busy, owner}, 2'b10);
      tick();
      chk("rd_acc2_en", mem_en, 1);
      chk("rd_acc2_done", cpu_done, 0);
      mem_rdata = 16'hBEEF;
      tick();
      chk("rd_resp_en", mem_en, 0);
      chk("rd_resp_done", {cpu_done, dma_done}, 2'b10);
      chk("rd_rdata", cpu_rdata, 16'hBEEF);
      cpu_req = 1'b0;
      tick();
      chk("rd_idle", {busy, cpu_done}, 0);

      // DMA write
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0020; dma_wdata = 16'h1234;
      mem_rdata = 16'hDEAD;
      tick();
      chk("wr_acc1", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 16'h0020, 16'h1234});
      chk("wr_owner", owner, 1);
      tick();
      chk("wr_acc2", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 16'h0020, 16'h1234});
      tick();
      chk("wr_resp_done", {cpu_done, dma_done}, 2'b01);
      chk("wr_resp_en", {mem_en, mem_we}, 0);
      chk("wr_dma_rdata", dma_rdata, 16'h0000);
      chk("wr_cpu_rdata", cpu_rdata, 16'hBEEF);
      dma_req = 1'b0; dma_we = 1'b0;
      tick();
      chk("wr_idle_done", dma_done, 0);

      // Both ports requesting continuously for four transactions
      exp_cpu_rd = 16'hBEEF; exp_dma_rd = 16'h0000;
      cpu_req = 1'b1; cpu_addr = 16'h0010;
      dma_req = 1'b1; dma_addr = 16'h0020;
      for (int i = 0; i < 4; i++) begin
         rd_val = 16'h1000 + 16'(i);
         tick();
         chk($sformatf("tie%0d_owner", i), owner, exp_own[i]);
         chk($sformatf("tie%0d_addr", i), mem_addr, exp_own[i] ? 16'h0020 : 16'h0010);
         tick();
         mem_rdata = rd_val;
         tick();
         if (exp_own[i]) exp_dma_rd = rd_val; else exp_cpu_rd = rd_val;
         chk($sformatf("tie%0d_done", i), {cpu_done, dma_done}, exp_own[i] ? 2'b01 : 2'b10);
         chk($sformatf("tie%0d_rdata", i), {cpu_rdata, dma_rdata}, {exp_cpu_rd, exp_dma_rd});
         if (i == 3) begin
            cpu_req = 1'b0; dma_req = 1'b0;
         end
         tick();
         chk($sformatf("tie%0d_idle", i), busy, 0);
      end

      // Requester address changes during the access
      cpu_req = 1'b1; cpu_addr = 16'h0010;
      tick();
      chk("hold_acc1_addr", mem_addr, 16'h0010);
      cpu_addr = 16'h0FFF;
      tick();
      chk("hold_acc2_addr", mem_addr, 16'h0010);
      mem_rdata = 16'h5A5A;
      tick();
      chk("hold_resp_addr", mem_addr, 16'h0010);
      chk("hold_resp_done", cpu_done, 1);
      chk("hold_rdata", cpu_rdata, 16'h5A5A);
      cpu_req = 1'b0;
      tick();

      // Asynchronous reset in the middle of an access
      cpu_req = 1'b1; cpu_addr = 16'h0030;
      tick();
      chk("arst_pre_en", mem_en, 1);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_en", mem_en, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", {cpu_done, dma_done}, 0);
      chk("arst_rdata", cpu_rdata, 0);
      cpu_req = 1'b0;
      tick();
      reset = 1'b1;
      cpu_req = 1'b1; cpu_addr = 16'h0044;
      dma_req = 1'b1; dma_addr = 16'h0055;
      tick();
      chk("arst_tie_owner", owner, 0);
      chk("arst_tie_addr", mem_addr, 16'h0044);
      tick();
      mem_rdata = 16'h7777;
      tick();
      chk("arst_tie_done", {cpu_done, dma_done}, 2'b10);
      chk("arst_tie_rdata", cpu_rdata, 16'h7777);
      cpu_req = 1'b0; dma_req = 1'b0;
      tick();

      // Zero wait states
      reset0 = 1'b1;
      tick();
      chk("w0_idle", {busy0, mem_en0}, 0);
      cpu_req0 = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040; mem_rdata = 16'hCAFE;
      tick();
      chk("w0_acc_en", mem_en0, 1);
      chk("w0_acc_addr", mem_addr0, 16'h0040);
      chk("w0_acc_done", cpu_done0, 0);
      tick();
      chk("w0_resp_en", mem_en0, 0);
      chk("w0_resp_done", {cpu_done0, dma_done0}, 2'b10);
      chk("w0_rdata", cpu_rdata0, 16'hCAFE);
      cpu_req0 = 1'b0;
      tick();
      chk("w0_idle_done", {busy0, cpu_done0}, 0);
      tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified instruction/data memory between the CPU multicycle controller (fetch, load, store) and a DMA/program-loader port.
- Runs request/done handshakes, latches the winner's command and holds it on the memory bus for a fixed wait-state count.
- Returns read data and pulses done to the winner.
- Sits between the controller/datapath memory interface and the memory array.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- WAIT_CYCLES, 1, extra memory cycles beyond the first (legal range 0..15).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held high until cpu_done.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_rdata  out  DW  registered CPU read data.
- cpu_done  out  1  one-cycle completion pulse to the CPU.
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_done: same as the CPU set, for the DMA port.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  latched address.
- mem_wdata  out  DW  latched write data.
- mem_rdata  in  DW  memory read data; valid in the last ACCESS cycle.
- busy  out  1  state != ARB_IDLE.
- owner  out  1  0 = CPU, 1 = DMA; valid while busy.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = ARB_IDLE.
  - All outputs 0: mem_*, rdata registers, done, busy, owner.
  - last_owner = DMA, so the CPU wins the first tie.
  - Any access in progress is dropped; no done is issued.
- States: ARB_IDLE, ARB_ACCESS, ARB_RESP.
- ARB_IDLE:
  - If no request is pending, stay.
  - If exactly one request is pending, grant it.
  - If both are pending, grant the port != last_owner (round-robin).
  - On grant: latch we/addr/wdata of the winner, set owner, load wait counter with WAIT_CYCLES, go to ARB_ACCESS.
- ARB_ACCESS:
  - mem_en = 1; mem_we/addr/wdata driven from the latched values.
  - If counter == 0: on a read, capture mem_rdata into the winner's rdata register; go to ARB_RESP.
  - Otherwise decrement the counter.
  - Occupancy is WAIT_CYCLES+1 cycles.
- ARB_RESP:
  - mem_en = 0.
  - Pulse the winner's done for exactly one cycle.
  - last_owner <= owner; go to ARB_IDLE.
- Latency: done is high exactly WAIT_CYCLES+2 cycles after the ARB_IDLE cycle in which the request was sampled. Back-to-back transactions occupy WAIT_CYCLES+3 cycles each.
- Handshake rules:
  - The requester drops req at the edge ending the done cycle. A req still high in the following ARB_IDLE is a new request.
  - A req deasserted mid-access does not abort the access; it completes and done still pulses.
  - The non-granted port's req is ignored until ARB_IDLE.
- Writes leave the rdata registers unchanged. An rdata register holds its value until its port's next read.
- Only one done is high per cycle. The two done signals are never high simultaneously.
- Latched command values are stable for the whole of ARB_ACCESS, even if the requester inputs change.
- Counter width is max(1, clog2(WAIT_CYCLES+1)). There is no wrap-around; the counter stops at 0.
- ARB_IDLE with a req arriving in the same cycle as the previous RESP: not possible, because RESP always returns to ARB_IDLE first.

Optional Feature:
- Macro: MEM_ARB_CPU_PRIORITY_EN.
- Defined: fixed priority. The CPU always wins a tie and last_owner is unused; the DMA port can starve while the CPU requests continuously.
- Undefined: round-robin as described above.

Decomposition:
- Shared package mem_arb_pkg:
  - State encoding: ARB_IDLE = 2'b00, ARB_ACCESS = 2'b01, ARB_RESP = 2'b10.
  - Owner constants: OWN_CPU = 1'b0, OWN_DMA = 1'b1.
  - Maximum WAIT_CYCLES constant (15).
- One natural sub-module: mem_arb_wait_cnt, a loadable down-counter.
  - Inputs: load, load value.
  - Output: zero flag.
- Winner selection and the FSM stay in the top module.

Test Plan:
- CPU read, WAIT_CYCLES = 1: cpu_req = 1, cpu_addr = 0x0010, mem_rdata = 0xBEEF in the last ACCESS cycle -> mem_en high for 2 cycles with mem_addr = 0x0010; cpu_done pulses 3 cycles after the request is sampled; cpu_rdata = 0xBEEF.
- DMA write: dma_we = 1, dma_addr = 0x0020, dma_wdata = 0x1234 -> mem_we = 1 and mem_wdata = 0x1234 for 2 cycles; dma_done pulses once; dma_rdata unchanged.
- Simultaneous requests, both held for 4 transactions -> grant order CPU, DMA, CPU, DMA. With MEM_ARB_CPU_PRIORITY_EN defined -> CPU, CPU, CPU, CPU.
- Requester changes cpu_addr from 0x0010 to 0x0FFF during ARB_ACCESS -> mem_addr stays 0x0010 until RESP.
- reset driven low in the middle of ARB_ACCESS -> mem_en, busy and both done signals are 0 immediately (no clock edge needed); after release, the next request is granted normally with the CPU winning the first tie.
- WAIT_CYCLES = 0: CPU read -> mem_en high for 1 cycle; cpu_done 2 cycles after sampling.
